// File: rtl/gj_matrix_inverse_seq.sv
// Sequential Gauss-Jordan inverter: NxN signed Q(W-FRAC).FRAC in, inv(A) out, row-major.
// Latency: sum_c[(N-c)+1+(W+FRAC)+2N+(N-1)(2N+1)] cycles from last input to first output.
// Backpressure: in_ready only in IDLE/LOAD; output holds data/last stable while out_ready is low.
module gj_matrix_inverse_seq #(
  parameter int N    = 5,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err_singular
);

  localparam int RIW = (N > 1) ? $clog2(N) : 1;   // row index width
  localparam int CIW = $clog2(2 * N);              // augmented column index width
  localparam int DW  = W + FRAC;                   // divider dividend/quotient width
  localparam int DCW = $clog2(DW);                 // divider step counter width

  localparam logic [RIW-1:0] R_ZERO = '0;
  localparam logic [RIW-1:0] R_ONE  = RIW'(1);
  localparam logic [RIW-1:0] R_LAST = RIW'(N - 1);
  localparam logic [CIW-1:0] C_N    = CIW'(N);
  localparam logic [CIW-1:0] C_LAST = CIW'(2 * N - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DW - 1);

  localparam logic signed [W-1:0] FX_ONE = W'(1) << FRAC;
  localparam logic signed [W-1:0] MAX_V  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};
  localparam logic [DW-1:0]       DIVIDEND = DW'(1) << (2 * FRAC);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_PSRCH = 4'd2;
  localparam logic [3:0] S_SWAP  = 4'd3;
  localparam logic [3:0] S_RECIP = 4'd4;
  localparam logic [3:0] S_NORM  = 4'd5;
  localparam logic [3:0] S_FACT  = 4'd6;
  localparam logic [3:0] S_ELIM  = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  logic [3:0] state;

  // Augmented matrix [A | I]; left half is consumed, right half becomes inv(A).
  logic signed [W-1:0] a [N][2*N];

  logic [RIW-1:0] c;          // pivot column
  logic [RIW-1:0] r;          // scan row in PSRCH, target row in FACT/ELIM
  logic [RIW-1:0] p;          // best pivot row so far
  logic [RIW-1:0] lr, lc;     // load position
  logic [RIW-1:0] orow, ocol; // output position
  logic [CIW-1:0] j;          // column sweep for NORM/ELIM
  logic [DCW-1:0] cnt;        // divider step

  logic [W-1:0]        best_abs;
  logic [W-1:0]        div_rem;
  logic [W-1:0]        div_den;
  logic [DW-1:0]       div_quo;
  logic                div_neg;
  logic signed [W-1:0] recip;
  logic signed [W-1:0] f;

  logic                  in_fire, out_fire, load_last, out_end;
  logic [CIW-1:0]        c_col, out_col;
  logic signed [W-1:0]   cur_el, piv_el, row_cj, row_ij;
  logic signed [W-1:0]   mul_x, mul_y, mul_res, elim_res, recip_n;
  logic [W-1:0]          cur_abs, fin_abs, rec_mag;
  logic [RIW-1:0]        fin_p, r_inc, r_inc2, nxt_row, first_row, last_row;
  logic signed [2*W-1:0] prod, prod_sh;
  logic [W:0]            diff, div_sh;
  logic [W-1:0]          rem_n;
  logic [DW-1:0]         quo_n;
  logic                  div_bit;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == S_OUT);
  assign out_fire  = out_valid && out_ready;
  assign load_last = (lr == R_LAST) && (lc == R_LAST);
  assign out_end   = (orow == R_LAST) && (ocol == R_LAST);
  assign out_last  = out_valid && out_end;
  assign out_data  = out_valid ? a[orow][out_col] : '0;

  // Shared datapath: pivot magnitude compare, one multiplier, saturating subtract, divider step.
  always_comb begin
    c_col   = CIW'(c);
    out_col = CIW'(ocol) + C_N;

    cur_el  = a[r][c_col];
    cur_abs = mag(cur_el);
    // First row of the scan always seeds the max; later rows need a strict win so ties keep the lower index.
    if ((r == c) || (cur_abs > best_abs)) begin
      fin_abs = cur_abs;
      fin_p   = r;
    end else begin
      fin_abs = best_abs;
      fin_p   = p;
    end
    piv_el = a[p][c_col];

    row_cj = a[c][j];
    row_ij = a[r][j];
    mul_x  = (state == S_ELIM) ? f      : row_cj;
    mul_y  = (state == S_ELIM) ? row_cj : recip;

    prod    = (2*W)'(mul_x) * (2*W)'(mul_y);
    prod_sh = prod >>> FRAC;
    if ((&prod_sh[2*W-1:W-1]) || ~(|prod_sh[2*W-1:W-1]))
      mul_res = prod_sh[W-1:0];
    else
      mul_res = prod_sh[2*W-1] ? MIN_V : MAX_V;

    diff = {row_ij[W-1], row_ij} - {mul_res[W-1], mul_res};
    if (diff[W] != diff[W-1])
      elim_res = diff[W] ? MIN_V : MAX_V;
    else
      elim_res = diff[W-1:0];

    // Restoring division on the pivot magnitude, one quotient bit per cycle.
    div_sh = {div_rem, div_quo[DW-1]};
    if (div_sh >= {1'b0, div_den}) begin
      div_bit = 1'b1;
      rem_n   = W'(div_sh - {1'b0, div_den});
    end else begin
      div_bit = 1'b0;
      rem_n   = div_sh[W-1:0];
    end
    quo_n   = {div_quo[DW-2:0], div_bit};
    // Tiny pivots give a reciprocal beyond W bits; clamp the magnitude before the sign goes back on.
    rec_mag = (|quo_n[DW-1:W-1]) ? MAX_V : quo_n[W-1:0];
    recip_n = div_neg ? (~rec_mag + W'(1)) : rec_mag;

    r_inc     = r + R_ONE;
    r_inc2    = r_inc + R_ONE;
    nxt_row   = (r_inc == c) ? r_inc2 : r_inc;
    first_row = (c == R_ZERO) ? R_ONE : R_ZERO;
    last_row  = (c == R_LAST) ? (R_LAST - R_ONE) : R_LAST;
  end

  // Control FSM, counters, divider state and job status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_singular <= 1'b0;
      c            <= '0;
      r            <= '0;
      p            <= '0;
      lr           <= '0;
      lc           <= '0;
      orow         <= '0;
      ocol         <= '0;
      j            <= '0;
      cnt          <= '0;
      best_abs     <= '0;
      div_rem      <= '0;
      div_den      <= '0;
      div_quo      <= '0;
      div_neg      <= 1'b0;
      recip        <= '0;
      f            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_fire) begin
            if (state == S_IDLE) begin
              busy         <= 1'b1;
              err_singular <= 1'b0;
            end
            if (load_last) begin
              lr    <= '0;
              lc    <= '0;
              c     <= '0;
              r     <= '0;
              state <= S_PSRCH;
            end else begin
              state <= S_LOAD;
              if (lc == R_LAST) begin
                lc <= '0;
                lr <= lr + R_ONE;
              end else begin
                lc <= lc + R_ONE;
              end
            end
          end
        end
        S_PSRCH: begin
          best_abs <= fin_abs;
          p        <= fin_p;
          if (r == R_LAST) begin
            if (fin_abs == '0) begin
              done         <= 1'b1;
              err_singular <= 1'b1;
              busy         <= 1'b0;
              state        <= S_IDLE;
            end else begin
              state <= S_SWAP;
            end
          end else begin
            r <= r + R_ONE;
          end
        end
        S_SWAP: begin
          // piv_el is row p before the swap, i.e. what lands on the diagonal.
          div_rem <= '0;
          div_quo <= DIVIDEND;
          div_den <= mag(piv_el);
          div_neg <= piv_el[W-1];
          cnt     <= '0;
          state   <= S_RECIP;
        end
        S_RECIP: begin
          div_rem <= rem_n;
          div_quo <= quo_n;
          cnt     <= cnt + DCW'(1);
          if (cnt == D_LAST) begin
            recip <= recip_n;
            j     <= '0;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (j == C_LAST) begin
            r     <= first_row;
            state <= S_FACT;
          end else begin
            j <= j + CIW'(1);
          end
        end
        S_FACT: begin
          f     <= a[r][c_col];
          j     <= '0;
          state <= S_ELIM;
        end
        S_ELIM: begin
          if (j == C_LAST) begin
            if (r == last_row) begin
              if (c == R_LAST) begin
                orow  <= '0;
                ocol  <= '0;
                state <= S_OUT;
              end else begin
                c     <= c + R_ONE;
                r     <= c + R_ONE;
                state <= S_PSRCH;
              end
            end else begin
              r     <= nxt_row;
              state <= S_FACT;
            end
          end else begin
            j <= j + CIW'(1);
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (out_end) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (ocol == R_LAST) begin
              ocol <= '0;
              orow <= orow + R_ONE;
            end else begin
              ocol <= ocol + R_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Matrix storage: load, identity init, row swap, normalisation and elimination writes.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE, S_LOAD: begin
        if (in_fire) begin
          a[lr][CIW'(lc)] <= in_data;
          if (state == S_IDLE) begin
            for (int ii = 0; ii < N; ii++) begin
              for (int jj = 0; jj < N; jj++) begin
                a[RIW'(ii)][CIW'(N + jj)] <= (ii == jj) ? FX_ONE : '0;
              end
            end
          end
        end
      end
      S_SWAP: begin
        for (int jj = 0; jj < 2 * N; jj++) begin
          a[c][CIW'(jj)] <= a[p][CIW'(jj)];
          a[p][CIW'(jj)] <= a[c][CIW'(jj)];
        end
      end
      S_NORM: a[c][j] <= mul_res;
      S_ELIM: a[r][j] <= elim_res;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gj_matrix_inverse_seq.sv
// Bench for gj_matrix_inverse_seq: directed matrices plus random jobs against a float-free GJ model.
// Checks reset values, latency, output order/stability under stalls, singular handling, abort by reset.
// Drives inputs on negedge, samples on negedge; every wait is bounded.
module tb_gj_matrix_inverse_seq;

  localparam int N    = 5;
  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam longint ONE  = longint'(1) <<< FRAC;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         err_singular;

  gj_matrix_inverse_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_singular (err_singular)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint mat_in  [N][N];
  longint exp_inv [N][N];
  bit     exp_sing;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic longint fsat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint fmul(input longint x, input longint y);
    return fsat((x * y) >>> FRAC);
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int lat_formula();
    int s = 0;
    for (int cc = 0; cc < N; cc++)
      s += (N - cc) + 1 + (W + FRAC) + 2 * N + (N - 1) * (2 * N + 1);
    return s;
  endfunction

  // Reference Gauss-Jordan with partial pivoting on plain integers.
  task automatic model();
    longint g [N][2*N];
    longint best, piv, q, rcp, fct, tmp;
    int     pr;
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < 2 * N; cc++)
        g[rr][cc] = (cc < N) ? mat_in[rr][cc] : ((cc - N == rr) ? ONE : 0);
    exp_sing = 0;
    for (int cc = 0; cc < N; cc++) begin
      best = -1;
      pr   = cc;
      for (int rr = cc; rr < N; rr++)
        if (labs(g[rr][cc]) > best) begin
          best = labs(g[rr][cc]);
          pr   = rr;
        end
      if (best == 0) begin
        exp_sing = 1;
        return;
      end
      for (int k = 0; k < 2 * N; k++) begin
        tmp = g[cc][k]; g[cc][k] = g[pr][k]; g[pr][k] = tmp;
      end
      piv = g[cc][cc];
      q   = (longint'(1) <<< (2 * FRAC)) / labs(piv);
      if (q > MAXV) q = MAXV;
      rcp = (piv < 0) ? -q : q;
      for (int k = 0; k < 2 * N; k++) g[cc][k] = fmul(g[cc][k], rcp);
      for (int rr = 0; rr < N; rr++) begin
        if (rr != cc) begin
          fct = g[rr][cc];
          for (int k = 0; k < 2 * N; k++) g[rr][k] = fsat(g[rr][k] - fmul(fct, g[cc][k]));
        end
      end
    end
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++) exp_inv[rr][cc] = g[rr][N + cc];
  endtask

  task automatic clear_all();
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++) begin
        mat_in[rr][cc]  = 0;
        exp_inv[rr][cc] = 0;
      end
    exp_sing = 0;
  endtask

  task automatic set_diag(input longint d0, input longint d1, input longint d2,
                          input longint d3, input longint d4);
    clear_all();
    mat_in[0][0] = d0; mat_in[1][1] = d1; mat_in[2][2] = d2;
    mat_in[3][3] = d3; mat_in[4][4] = d4;
  endtask

  task automatic load_matrix();
    int t;
    for (int k = 0; k < N * N; k++) begin
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("in_ready_wait", 0, 1);
      in_valid = 1'b1;
      in_data  = W'(mat_in[k / N][k % N]);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input bit stall, input bit check_lat);
    int           cyc, t, idx;
    bit           prev_stall, rdy;
    logic [W-1:0] prev_data, ev;
    logic         prev_last;
    cyc = 1;
    chk("busy_run", 64'(busy), 1);
    while (!(out_valid || done) && cyc <= 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc > 3000) begin
      chk("job_timeout", 0, 1);
      return;
    end
    if (exp_sing) begin
      chk("sing_done", 64'(done), 1);
      chk("sing_err", 64'(err_singular), 1);
      chk("sing_no_valid", 64'(out_valid), 0);
      chk("sing_busy", 64'(busy), 0);
      @(negedge clk);
      chk("sing_done_pulse", 64'(done), 0);
      chk("sing_err_held", 64'(err_singular), 1);
      chk("sing_no_valid2", 64'(out_valid), 0);
      return;
    end
    chk("early_done", 64'(done), 0);
    if (check_lat) chk("latency", 64'(cyc - 1), 64'(lat_formula()));
    idx = 0; t = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    while (idx < N * N && t < 2000) begin
      chk("valid_held", 64'(out_valid), 1);
      if (prev_stall) begin
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      rdy       = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        ev = W'(exp_inv[idx / N][idx % N]);
        chk($sformatf("data[%0d]", idx), 64'(out_data), 64'(ev));
        chk($sformatf("last[%0d]", idx), 64'(out_last), 64'(idx == N * N - 1));
        idx++;
      end
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
      t++;
    end
    if (idx < N * N) chk("out_timeout", 0, 1);
    out_ready = 1'b0;
    chk("done_pulse", 64'(done), 1);
    chk("done_err", 64'(err_singular), 0);
    chk("done_busy", 64'(busy), 0);
    chk("done_no_valid", 64'(out_valid), 0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
  endtask

  task automatic run_job(input bit stall, input bit check_lat);
    load_matrix();
    finish_job(stall, check_lat);
  endtask

  task automatic reset_outputs_chk(input string pfx);
    chk({pfx, "_in_ready"}, 64'(in_ready), 1);
    chk({pfx, "_out_valid"}, 64'(out_valid), 0);
    chk({pfx, "_out_data"}, 64'(out_data), 0);
    chk({pfx, "_out_last"}, 64'(out_last), 0);
    chk({pfx, "_busy"}, 64'(busy), 0);
    chk({pfx, "_done"}, 64'(done), 0);
    chk({pfx, "_err"}, 64'(err_singular), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs_chk("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);

    // Identity
    set_diag(ONE, ONE, ONE, ONE, ONE);
    for (int i = 0; i < N; i++) exp_inv[i][i] = ONE;
    run_job(0, 1);

    // Diagonal {2,4,8,1,-1}
    set_diag(2 * ONE, 4 * ONE, 8 * ONE, ONE, -ONE);
    exp_inv[0][0] = 64'h8000; exp_inv[1][1] = 64'h4000; exp_inv[2][2] = 64'h2000;
    exp_inv[3][3] = 64'h10000; exp_inv[4][4] = -64'sh10000;
    run_job(0, 1);

    // Cyclic permutation, a[0][0]=0 forces a swap; inverse is the transpose
    clear_all();
    for (int i = 0; i < N; i++) begin
      mat_in[i][(i + 1) % N]  = ONE;
      exp_inv[(i + 1) % N][i] = ONE;
    end
    run_job(0, 1);

    // Rows 0 and 1 equal: singular, no output
    clear_all();
    mat_in[0][0] = ONE; mat_in[0][1] = 2 * ONE;
    mat_in[1][0] = ONE; mat_in[1][1] = 2 * ONE;
    mat_in[2][2] = ONE; mat_in[3][3] = ONE; mat_in[4][4] = ONE;
    exp_sing = 1;
    run_job(0, 0);

    // Identity after singular clears err_singular; with random out_ready stalls
    set_diag(ONE, ONE, ONE, ONE, ONE);
    for (int i = 0; i < N; i++) exp_inv[i][i] = ONE;
    load_matrix();
    chk("err_cleared", 64'(err_singular), 0);
    finish_job(1, 1);

    // Reset during ELIM of column 2 aborts the job
    clear_all();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) mat_in[i][k] = (i == k) ? 3 * ONE : longint'($urandom_range(0, 65535));
    load_matrix();
    repeat (289) @(negedge clk);
    chk("abort_busy", 64'(busy), 1);
    chk("abort_no_valid", 64'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    reset_outputs_chk("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_diag(2 * ONE, 2 * ONE, 2 * ONE, 2 * ONE, 2 * ONE);
    for (int i = 0; i < N; i++) exp_inv[i][i] = 64'h8000;
    run_job(0, 1);

    // Random matrices against the model
    for (int jb = 0; jb < 4; jb++) begin
      clear_all();
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++)
          mat_in[i][k] = longint'($urandom_range(0, 8 * 65536)) - 4 * ONE;
      model();
      run_job(jb[0], !exp_sing);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
